// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 16-bit mips CPU: loader-filled instruction memory, data memory, run control FSM.
// Optional macro CPU_MEM_RESPONDER_GUARD_EN drops stores whose upper address bits are non-zero and flags addr_fault.
module cpu_mem_responder #(
  parameter int DMEM_AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pc,
  output logic [15:0] instr,
  input  logic        memwrite,
  input  logic [15:0] aluout,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic        load_last,
  output logic        cpu_reset,
  output logic        halted,
  output logic [15:0] cycle_count,
  output logic [15:0] store_count,
  output logic        addr_fault
);

  localparam int          DMEM_DEPTH = 1 << DMEM_AW;
  localparam logic [15:0] NOP_INSTR  = 16'h0800;
  localparam logic [15:0] HALT_INSTR = 16'hD800;
  localparam logic [4:0]  HALT_OP    = 5'b11011;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         lptr_q, lptr_d;
  logic [15:0]        cycle_q, cycle_d;
  logic [15:0]        store_q, store_d;
  logic [15:0]        imem_q [256];
  logic [15:0]        dmem_q [DMEM_DEPTH];
  logic [15:0]        imem_rd_s;
  logic [DMEM_AW-1:0] daddr_s;
  logic               load_we_s;
  logic               store_req_s;
  logic               store_we_s;
  logic               drop_s;

  assign daddr_s     = aluout[DMEM_AW-1:0];
  assign imem_rd_s   = imem_q[pc];
  assign readdata    = dmem_q[daddr_s];
  assign cycle_count = cycle_q;
  assign store_count = store_q;

`ifdef CPU_MEM_RESPONDER_GUARD_EN
  logic fault_q, fault_d;

  assign drop_s     = |aluout[15:DMEM_AW];
  assign addr_fault = fault_q;

  // Sticky out-of-range store flag
  always_comb begin
    fault_d = fault_q;
    if (store_req_s && drop_s) begin
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end
  end

  // Fault flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  logic unused_hi_s;

  assign unused_hi_s = |aluout[15:DMEM_AW];
  assign drop_s      = 1'b0;
  assign addr_fault  = 1'b0;
`endif

  // Next-state, counters and per-state outputs
  always_comb begin
    state_d     = state_q;
    lptr_d      = lptr_q;
    cycle_d     = cycle_q;
    store_d     = store_q;
    load_we_s   = 1'b0;
    store_req_s = 1'b0;
    load_ready  = 1'b0;
    cpu_reset   = 1'b0;
    halted      = 1'b0;
    instr       = NOP_INSTR;
    case (state_q)
      S_LOAD: begin
        load_ready = 1'b1;
        cpu_reset  = 1'b1;
        instr      = NOP_INSTR;
        if (load_valid) begin
          load_we_s = 1'b1;
          lptr_d    = lptr_q + 8'd1;
          if (load_last) begin
            state_d = S_RUN;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          lptr_d = lptr_q;
        end
      end
      S_RUN: begin
        instr       = imem_rd_s;
        store_req_s = memwrite;
        if (cycle_q != 16'hFFFF) begin
          cycle_d = cycle_q + 16'd1;
        end else begin
          cycle_d = cycle_q;
        end
        // The HALT cycle itself still counts and may still store
        if (imem_rd_s[15:11] == HALT_OP) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_RUN;
        end
      end
      S_HALTED: begin
        halted = 1'b1;
        instr  = HALT_INSTR;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
    store_we_s = store_req_s & ~drop_s;
    if (store_we_s && (store_q != 16'hFFFF)) begin
      store_d = store_q + 16'd1;
    end else begin
      store_d = store_q;
    end
  end

  // State, load pointer and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      lptr_q  <= 8'd0;
      cycle_q <= 16'd0;
      store_q <= 16'd0;
    end else begin
      state_q <= state_d;
      lptr_q  <= lptr_d;
      cycle_q <= cycle_d;
      store_q <= store_d;
    end
  end

  // Memory arrays keep contents across reset; writes on a reset edge are dropped
  always_ff @(posedge clk) begin
    if (load_we_s && !reset) begin
      imem_q[lptr_q] <= load_data;
    end
    if (store_we_s && !reset) begin
      dmem_q[daddr_s] <= writedata;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed program scenarios followed by random traffic, all checked
// against a transaction-level model of the load/run/halt behaviour and the two memories.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic        memwrite;
  logic [15:0] aluout;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_last;
  logic        cpu_reset;
  logic        halted;
  logic [15:0] cycle_count;
  logic [15:0] store_count;
  logic        addr_fault;

  always #5 clk = ~clk;

  cpu_mem_responder #(.DMEM_AW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instr       (instr),
    .memwrite    (memwrite),
    .aluout      (aluout),
    .writedata   (writedata),
    .readdata    (readdata),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .cpu_reset   (cpu_reset),
    .halted      (halted),
    .cycle_count (cycle_count),
    .store_count (store_count),
    .addr_fault  (addr_fault)
  );

`ifdef CPU_MEM_RESPONDER_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef enum int {M_LOAD, M_RUN, M_HALT} mstate_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  bit          armed  = 1'b0;
  mstate_t     m_state = M_LOAD;
  int          m_lptr, m_cycles, m_stores;
  bit          m_fault;
  logic [15:0] m_imem [256];
  bit          m_ivld [256];
  logic [15:0] m_dmem [256];
  bit          m_dvld [256];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs for the current model state and current inputs
  task automatic check_outputs();
    logic [15:0] exp_instr;
    bit          known;
    known = 1'b1;
    case (m_state)
      M_LOAD:  exp_instr = 16'h0800;
      M_RUN:   begin exp_instr = m_imem[pc]; known = m_ivld[pc]; end
      default: exp_instr = 16'hD800;
    endcase
    if (known) check_eq("instr", {16'd0, instr}, {16'd0, exp_instr});
    if (m_dvld[aluout[7:0]]) check_eq("readdata", {16'd0, readdata}, {16'd0, m_dmem[aluout[7:0]]});
    check_eq("load_ready", {31'd0, load_ready}, {31'd0, m_state == M_LOAD});
    check_eq("cpu_reset", {31'd0, cpu_reset}, {31'd0, m_state == M_LOAD});
    check_eq("halted", {31'd0, halted}, {31'd0, m_state == M_HALT});
    check_eq("cycle_count", {16'd0, cycle_count}, m_cycles);
    check_eq("store_count", {16'd0, store_count}, m_stores);
    check_eq("addr_fault", {31'd0, addr_fault}, {31'd0, m_fault});
  endtask

  // Apply one clock edge to the model using the inputs held across it
  task automatic model_edge();
    logic [15:0] cur;
    if (reset) begin
      armed    = 1'b1;
      m_state  = M_LOAD;
      m_lptr   = 0;
      m_cycles = 0;
      m_stores = 0;
      m_fault  = 1'b0;
    end else begin
      case (m_state)
        M_LOAD: begin
          if (load_valid) begin
            m_imem[m_lptr] = load_data;
            m_ivld[m_lptr] = 1'b1;
            m_lptr = (m_lptr + 1) % 256;
            if (load_last) m_state = M_RUN;
          end
        end
        M_RUN: begin
          cur = m_imem[pc];
          if (memwrite) begin
            if (GUARD && (aluout >> 8) != 16'd0) begin
              m_fault = 1'b1;
            end else begin
              m_dmem[aluout % 256] = writedata;
              m_dvld[aluout % 256] = 1'b1;
              if (m_stores < 65535) m_stores++;
            end
          end
          if (m_cycles < 65535) m_cycles++;
          if (cur[15:11] == 5'b11011) m_state = M_HALT;
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (armed) check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load_word(input logic [15:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic run_cycle(input logic [7:0] p, input logic we, input logic [15:0] a, input logic [15:0] wd);
    pc        = p;
    memwrite  = we;
    aluout    = a;
    writedata = wd;
    step();
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b1; pc = 8'd0; memwrite = 1'b0; aluout = 16'd0; writedata = 16'd0;
    load_valid = 1'b0; load_data = 16'd0; load_last = 1'b0;
    for (int i = 0; i < 256; i++) begin m_ivld[i] = 1'b0; m_dvld[i] = 1'b0; end
    #1;
    step();
    step();
    reset = 1'b0;
    step();

    // Three-word program with stores attempted during LOAD
    memwrite = 1'b1; aluout = 16'h0005; writedata = 16'hBEEF;
    load_word(16'h8900, 1'b0);
    load_word(16'h0800, 1'b0);
    load_word(16'hD800, 1'b1);
    run_cycle(8'd0, 1'b0, 16'h0005, 16'h0000);
    run_cycle(8'd1, 1'b1, 16'h0001, 16'h0023);
    run_cycle(8'd1, 1'b0, 16'h0001, 16'h0000);
    run_cycle(8'd2, 1'b0, 16'h0001, 16'h0000);
    run_cycle(8'd0, 1'b1, 16'h0001, 16'hFFFF);
    run_cycle(8'd0, 1'b0, 16'h0001, 16'h0000);
    check_eq("halt_cycles", {16'd0, cycle_count}, 32'd4);
    check_eq("halt_stores", {16'd0, store_count}, 32'd1);

    // Out-of-range store, then a mid-run reset with a store asserted
    reset = 1'b1; step(); reset = 1'b0;
    load_word(16'h0800, 1'b1);
    run_cycle(8'd0, 1'b1, 16'h0101, 16'h0055);
    run_cycle(8'd0, 1'b0, 16'h0001, 16'h0000);
    run_cycle(8'd0, 1'b1, 16'h0002, 16'h0AAA);
    reset = 1'b1;
    run_cycle(8'd0, 1'b1, 16'h0002, 16'h1234);
    reset = 1'b0;
    run_cycle(8'd0, 1'b0, 16'h0002, 16'h0000);
    load_word(16'h0800, 1'b1);
    for (int p = 0; p < 4; p++) run_cycle(8'(p), 1'b0, 16'h0002, 16'h0000);

    // 257-word stream wraps the load pointer onto word 0
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 257; i++) begin
      w = 16'($urandom);
      load_word(w, (i == 256) ? 1'b1 : 1'b0);
    end
    run_cycle(8'd0, 1'b0, 16'h0000, 16'h0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 47) == 0);
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 16'($urandom);
      load_last  = ($urandom_range(0, 7) == 0);
      memwrite   = 1'($urandom_range(0, 1));
      aluout     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      writedata  = 16'($urandom);
      pc         = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the single-clock 16-bit CPU (`mips`): drives `instr` and `readdata` and absorbs `memwrite`/`writedata`/`aluout`, replacing the hand-driven stimulus used by the CPU benches. Contains a 256×16 instruction memory filled through a valid/ready loader port and a data memory written by CPU stores. A small FSM holds the CPU in reset while loading, runs it, and stops it on HALT. It also keeps run-cycle and store counters.

## Interface
Parameters:
- `DMEM_AW`, 8: data-memory address width (depth 2^DMEM_AW words, 16-bit).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pc` in 8: CPU fetch address.
- `instr` out 16: instruction to CPU.
- `memwrite` in 1: CPU store strobe.
- `aluout` in 16: CPU data address.
- `writedata` in 16: CPU store data.
- `readdata` out 16: load data to CPU.
- `load_valid` in 1, `load_ready` out 1, `load_data` in 16, `load_last` in 1: program loader handshake.
- `cpu_reset` out 1: reset to CPU.
- `halted` out 1: CPU executed HALT.
- `cycle_count` out 16: RUN cycles.
- `store_count` out 16: accepted stores.
- `addr_fault` out 1: sticky out-of-range store (see Configuration).

## Operation
- States: LOAD, RUN, HALTED. Reset → LOAD.
- LOAD:
  - `load_ready`=1, `cpu_reset`=1, `instr`=NOP (16'h0800).
  - Transfer when `load_valid`&&`load_ready` at a clock edge: `imem[lptr]`←`load_data`, then `lptr`++.
  - `lptr` is 8-bit; after 256 words it wraps to 0 and overwrites.
  - Transfer with `load_last`=1 → RUN.
  - `load_last` without `load_valid` is ignored.
- RUN:
  - `load_ready`=0, `cpu_reset`=0, `instr`=`imem[pc]` (combinational).
  - If `instr[15:11]`==5'b11011 (HALT) → HALTED at next edge.
  - `cycle_count` increments every RUN cycle, including the HALT cycle, saturating at 16'hFFFF.
- HALTED:
  - `halted`=1, `instr`=16'hD800 (HALT), `cpu_reset`=0.
  - Counters frozen; stores ignored.
  - Exit only via `reset`.
- Data memory:
  - `readdata`=`dmem[aluout[DMEM_AW-1:0]]` combinational, in every state.
  - Write `dmem[aluout[DMEM_AW-1:0]]`←`writedata` at an edge when `memwrite`=1 and state=RUN. `store_count`++ per write, saturating.
  - `memwrite` in LOAD/HALTED is ignored and not counted.
- `reset` has priority over every event:
  - state→LOAD; `lptr`, `cycle_count`, `store_count`, `addr_fault` → 0.
  - A transfer or store on the reset edge is dropped.
  - Memory arrays are not cleared; mid-run reset keeps loaded program and data.

## Timing
- Reset values: `instr`=16'h0800, `readdata`=`dmem[aluout]` (array content, no reset), `load_ready`=1, `cpu_reset`=1, `halted`=0, all counters 0, `addr_fault`=0.
- Read paths are zero latency; imem/dmem writes are visible on the cycle after the write edge.
- Load-to-run:
  - Edge accepting `load_last` → `cpu_reset`=0 and `load_ready`=0 in the following cycle.
  - The CPU's first fetch happens in that cycle, at `pc`=0 as left by its reset.
- HALT: in the cycle `instr` decodes HALT, `halted` is still 0; `halted`=1 from the next edge.
- A store in the HALT-decode cycle is still accepted (RUN), though HALT itself never stores.

## Configuration
- `CPU_MEM_RESPONDER_GUARD_EN` defined:
  - A store with `aluout[15:DMEM_AW]`≠0 is dropped (no dmem write, `store_count` unchanged).
  - The drop sets `addr_fault`=1, sticky until `reset`.
  - Loads are still served from the low bits.
- Undefined:
  - Upper `aluout` bits are ignored; all stores use the low bits.
  - `addr_fault` is tied 0.

## Test plan
- Reset, load 3 words {16'h8900 LOAD s1, 16'h0800, 16'hD800} with `load_last` on word 3 → `load_ready` falls the cycle after word 3, `cpu_reset`=0; `instr`=16'h8900 at `pc`=0; `halted`=1 one cycle after `pc`=2; `cycle_count`=3.
- In RUN, `memwrite`=1, `aluout`=16'h0001, `writedata`=16'h0023 → next cycle `readdata`=16'h0023 with `aluout`=1; `store_count`=1.
- `memwrite`=1 during LOAD and during HALTED → dmem unchanged, `store_count` unchanged.
- With guard defined: store to `aluout`=16'h0101 → `dmem[1]` unchanged, `addr_fault`=1 until reset. Without guard: `dmem[1]`←data, `addr_fault`=0.
- Stream 257 words, last flagged on word 257 → `imem[0]` holds word 257.
- `reset` mid-RUN with a store asserted → store dropped, state LOAD, counters 0; `imem` retained (reload of 0 words is impossible, so a single-word re-load of word 0 reruns).
